cla_serial_seq: RTL and testbench



---
 rtl/cla_serial_seq_if.sv | 27 ++
 rtl/cla_serial_seq.sv | 146 ++++++++++++++
 tb/tb_cla_serial_seq.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/cla_serial_seq_if.sv
// Handshake and data bundle for the nibble-serial add/subtract sequencer.
// The producer/consumer side uses the master modport; the sequencer uses slave.
interface cla_serial_seq_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;
  logic             busy;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, result, cout, ovf, busy
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, result, cout, ovf, busy
  );
endinterface

// File: rtl/cla_serial_seq.sv
// Multi-cycle add/subtract sequencer: one shared 4-bit carry-lookahead slice
// processes one nibble per clock, LSB first, with the carry registered between
// nibbles. Valid/ready handshakes on both the operand and result sides.
module cla_serial_seq #(
  parameter int WIDTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  cla_serial_seq_if.slave   bus
);

  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CW-1:0] LAST_NIB = CW'(NIB - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  // Slice signals for the nibble currently selected by cnt_q.
  logic [CW+1:0]    nib_lsb;
  logic [3:0]       nib_a, nib_b;
  logic [3:0]       gen, prop;
  logic [3:0]       c_in;
  logic             slice_cout;
  logic [3:0]       slice_sum;

  assign nib_lsb = {cnt_q, 2'b00};

  // Shared 4-bit carry-lookahead slice: all internal carries derived from
  // generate/propagate terms and the registered carry-in, no ripple.
  always_comb begin
    nib_a   = opa_q[nib_lsb +: 4];
    nib_b   = opb_q[nib_lsb +: 4];
    gen     = nib_a & nib_b;
    prop    = nib_a ^ nib_b;
    c_in[0] = carry_q;
    c_in[1] = gen[0] | (prop[0] & carry_q);
    c_in[2] = gen[1] | (prop[1] & gen[0]) | (prop[1] & prop[0] & carry_q);
    c_in[3] = gen[2] | (prop[2] & gen[1]) | (prop[2] & prop[1] & gen[0])
            | (prop[2] & prop[1] & prop[0] & carry_q);
    slice_cout = gen[3] | (prop[3] & gen[2]) | (prop[3] & prop[2] & gen[1])
               | (prop[3] & prop[2] & prop[1] & gen[0])
               | (prop[3] & prop[2] & prop[1] & prop[0] & carry_q);
    slice_sum  = prop ^ c_in;
  end

  // Next-state and datapath update for the IDLE -> RUN -> DONE sequence.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned; a missing default would infer a latch.
    state_d  = state_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          // Subtraction is A + ~B + 1: invert B here and seed the carry with 1.
          opa_d    = bus.a;
          opb_d    = bus.sub ? ~bus.b : bus.b;
          carry_d  = bus.sub;
          cnt_d    = '0;
          result_d = '0;
          state_d  = S_RUN;
        end
      end

      S_RUN: begin
        result_d[nib_lsb +: 4] = slice_sum;
        carry_d                = slice_cout;
        if (cnt_q == LAST_NIB) begin
          // Counter holds at the last nibble instead of wrapping.
          cout_d  = slice_cout;
          ovf_d   = (opa_q[WIDTH-1] == opb_q[WIDTH-1]) &&
                    (slice_sum[3] != opa_q[WIDTH-1]);
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: operand and counter registers are reset along with the FSM so the
    // visible outputs are deterministic straight out of reset.
    if (!rst_n) begin
      state_q  <= S_IDLE;
      opa_q    <= '0;
      opb_q    <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q  <= state_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  // Handshake flags decode directly from the state register.
  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.result    = result_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_cla_serial_seq.sv
// Scoreboard bench for cla_serial_seq: stimulus pushes expected results at the
// accept edge; an independent monitor pops and compares on every result handshake.
module tb_cla_serial_seq;

  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;

  typedef struct packed {
    logic [WIDTH-1:0] r;
    logic             c;
    logic             o;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  exp_t sb_q[$];

  cla_serial_seq_if #(.WIDTH(WIDTH)) bus ();

  cla_serial_seq #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: on every result handshake, compare against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.out_valid && bus.out_ready) begin
        if (sb_q.size() == 0) begin
          check("sb_output_without_expectation", 32'(sb_q.size()), 32'd1);
        end else begin
          e = sb_q.pop_front();
          check("sb_result", 32'(bus.result), 32'(e.r));
          check("sb_cout",   32'(bus.cout),   32'(e.c));
          check("sb_ovf",    32'(bus.ovf),    32'(e.o));
        end
      end
    end
  end

  // Wait (bounded) until the sequencer is back in IDLE.
  task automatic wait_ready();
    for (int i = 0; i < 50 && !bus.in_ready; i++) begin
      @(posedge clk);
      #1;
    end
    check("in_ready_timeout", 32'(bus.in_ready), 32'd1);
  endtask

  // Issue one operation, scramble inputs after the accept edge, and verify
  // that out_valid rises exactly NIB edges after acceptance.
  task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                        input logic ts, input logic [WIDTH-1:0] er,
                        input logic ec, input logic eo);
    exp_t e;
    wait_ready();
    bus.a        = ta;
    bus.b        = tb_v;
    bus.sub      = ts;
    bus.in_valid = 1'b1;
    e.r = er;
    e.c = ec;
    e.o = eo;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.a        = 16'hDEAD;
    bus.b        = 16'hBEEF;
    bus.sub      = ~ts;
    repeat (NIB - 1) @(posedge clk);
    #1;
    check("latency_early_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    #1;
    check("latency_valid", 32'(bus.out_valid), 32'd1);
  endtask

  initial begin
    exp_t e;
    n_checks      = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b1;

    #3;
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_busy",      32'(bus.busy),      32'd0);
    check("rst_result",    32'(bus.result),    32'd0);
    check("rst_cout",      32'(bus.cout),      32'd0);
    check("rst_ovf",       32'(bus.ovf),       32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed vectors.
    run_op(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_op(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    run_op(16'hA000, 16'h9000, 1'b0, 16'h3000, 1'b1, 1'b1);

    // Backpressure: hold DONE while new operands are offered.
    wait_ready();
    bus.out_ready = 1'b0;
    run_op(16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0);
    bus.a        = 16'h1111;
    bus.b        = 16'h2222;
    bus.sub      = 1'b0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("bp_out_valid", 32'(bus.out_valid), 32'd1);
      check("bp_in_ready",  32'(bus.in_ready),  32'd0);
      check("bp_result",    32'(bus.result),    32'h1000);
      check("bp_cout",      32'(bus.cout),      32'd0);
      check("bp_ovf",       32'(bus.ovf),       32'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_in_ready_after_hs",  32'(bus.in_ready),  32'd1);
    check("bp_out_valid_after_hs", 32'(bus.out_valid), 32'd0);
    e.r = 16'h3333;
    e.c = 1'b0;
    e.o = 1'b0;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("bp_new_op_accepted", 32'(bus.busy), 32'd1);
    wait_ready();

    // Reset during the second RUN cycle aborts the operation.
    bus.a        = 16'h1234;
    bus.b        = 16'h1111;
    bus.sub      = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("mid_run_busy",    32'(bus.busy),   32'd1);
    check("mid_run_partial", 32'(bus.result), 32'h0005);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 32'(bus.out_valid), 32'd0);
    check("abort_busy",      32'(bus.busy),      32'd0);
    check("abort_result",    32'(bus.result),    32'd0);
    check("abort_cout",      32'(bus.cout),      32'd0);
    check("abort_ovf",       32'(bus.ovf),       32'd0);
    check("abort_in_ready",  32'(bus.in_ready),  32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_op(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);
    wait_ready();

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
